// File: rtl/z80_exec_pkg.sv
// Shared definitions for the Z80 ED-prefix multi-byte executors.
package z80_exec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ED,
    S_F_OP,
    S_F_NL,
    S_F_NH,
    S_R_LO,
    S_R_HI,
    S_WB
  } exec_state_e;

  localparam logic [7:0] ED_PREFIX      = 8'hED;
  localparam logic [7:0] LD_DD_NN_MASK  = 8'hCF;
  localparam logic [7:0] LD_DD_NN_MATCH = 8'h4B;
  localparam logic [1:0] REGPAIR_BASE   = 2'b10;

  function automatic logic is_ld_dd_nn(input logic [7:0] op);
    return (op & LD_DD_NN_MASK) == LD_DD_NN_MATCH;
  endfunction

endpackage

// File: rtl/z80_bus_req_timer.sv
// Wait-state counter for one outstanding bus read; flags a timeout after
// MAX_WAIT consecutive cycles of request without acknowledge.
module z80_bus_req_timer #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new request always follows either an idle cycle or an ack, so clearing
  // on both covers every request entry.
  always_comb begin
    timeout_o = req_i && !ack_i && (cnt_q == CNT_W'(MAX_WAIT - 1));
    if (!req_i || ack_i || timeout_o) cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/z80_ld_dd_extaddr_exec.sv
// Sequential executor for LD dd,(nn) (ED 01dd1011 nnL nnH): fetch, two data
// reads, register write-back and z80fi retire trace.
module z80_ld_dd_extaddr_exec
  import z80_exec_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] pc_in,
  output logic        busy,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        reg_wr,
  output logic [3:0]  reg_wnum,
  output logic [15:0] reg_wdata,
  output logic [15:0] pc_wdata,
  output logic        done,
  output logic        illegal,
  output logic        bus_err,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_mem_raddr,
  output logic [15:0] z80fi_mem_raddr2,
  output logic [15:0] z80fi_mem_rdata
);

  exec_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op_q, op_d, nl_q, nl_d, nh_q, nh_d, lo_q, lo_d;
  logic        illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [3:0]  wnum_q, wnum_d, len_q, len_d;
  logic [15:0] wdata_q, wdata_d, pcw_q, pcw_d;
  logic [31:0] insn_q, insn_d;
  logic [15:0] raddr_q, raddr_d, raddr2_q, raddr2_d;
  logic [15:0] nn;
  logic        timeout;

  assign nn = {nh_q, nl_q};

  z80_bus_req_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (mem_rd),
    .ack_i     (mem_ack),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    nl_d      = nl_q;
    nh_d      = nh_q;
    lo_d      = lo_q;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    wnum_d    = wnum_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    pcw_d     = pcw_q;
    insn_d    = insn_q;
    raddr_d   = raddr_q;
    raddr2_d  = raddr2_q;
    mem_rd    = 1'b0;
    mem_addr  = '0;

    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with a terminating pulse is dropped.
        if (start && !illegal_q && !bus_err_q) begin
          pc_d    = pc_in;
          state_d = S_F_ED;
        end
      end
      S_F_ED: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          if (mem_data == ED_PREFIX) state_d = S_F_OP;
          else begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_F_OP: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + 16'd1;
        if (mem_ack) begin
          if (is_ld_dd_nn(mem_data)) begin
            op_d    = mem_data;
            state_d = S_F_NL;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_F_NL: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + 16'd2;
        if (mem_ack) begin
          nl_d    = mem_data;
          state_d = S_F_NH;
        end
      end
      S_F_NH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + 16'd3;
        if (mem_ack) begin
          nh_d    = mem_data;
          state_d = S_R_LO;
        end
      end
      S_R_LO: begin
        mem_rd   = 1'b1;
        mem_addr = nn;
        if (mem_ack) begin
          lo_d    = mem_data;
          state_d = S_R_HI;
        end
      end
      S_R_HI: begin
        mem_rd   = 1'b1;
        mem_addr = nn + 16'd1;
        if (mem_ack) begin
          // Result and trace registers load together and hold until the next retire.
          wnum_d   = {REGPAIR_BASE, op_q[5:4]};
          wdata_d  = {mem_data, lo_q};
          pcw_d    = pc_q + 16'd4;
          insn_d   = {nh_q, nl_q, op_q, ED_PREFIX};
          len_d    = 4'd4;
          raddr_d  = nn;
          raddr2_d = nn + 16'd1;
          state_d  = S_WB;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      bus_err_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      op_q      <= '0;
      nl_q      <= '0;
      nh_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wnum_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      pcw_q     <= '0;
      insn_q    <= '0;
      raddr_q   <= '0;
      raddr2_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      nl_q      <= nl_d;
      nh_q      <= nh_d;
      lo_q      <= lo_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wnum_q    <= wnum_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      pcw_q     <= pcw_d;
      insn_q    <= insn_d;
      raddr_q   <= raddr_d;
      raddr2_q  <= raddr2_d;
    end
  end

  assign busy             = (state_q != S_IDLE) && (state_q != S_WB);
  assign done             = (state_q == S_WB);
  assign reg_wr           = done;
  assign z80fi_valid      = done;
  assign illegal          = illegal_q;
  assign bus_err          = bus_err_q;
  assign reg_wnum         = wnum_q;
  assign reg_wdata        = wdata_q;
  assign pc_wdata         = pcw_q;
  assign z80fi_insn       = insn_q;
  assign z80fi_insn_len   = len_q;
  assign z80fi_mem_raddr  = raddr_q;
  assign z80fi_mem_raddr2 = raddr2_q;
  assign z80fi_mem_rdata  = wdata_q;

endmodule

// File: tb/tb_z80_ld_dd_extaddr_exec.sv
// Directed bench for z80_ld_dd_extaddr_exec with a wait-state memory responder.
module tb_z80_ld_dd_extaddr_exec;

  logic        clk = 1'b0;
  logic        reset_n, start, mem_ack, mem_rd, busy;
  logic [15:0] pc_in, mem_addr, reg_wdata, pc_wdata;
  logic [7:0]  mem_data;
  logic        reg_wr, done, illegal, bus_err, z80fi_valid;
  logic [3:0]  reg_wnum, z80fi_insn_len;
  logic [31:0] z80fi_insn;
  logic [15:0] z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_rdata;

  logic [7:0]  mem [0:65535];
  int          waits, wcnt;
  logic        stall_en;
  logic [15:0] stall_addr;
  logic [15:0] acc_log[$];
  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  z80_ld_dd_extaddr_exec #(.MAX_WAIT(255), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .reg_wr(reg_wr), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata), .pc_wdata(pc_wdata),
    .done(done), .illegal(illegal), .bus_err(bus_err), .z80fi_valid(z80fi_valid),
    .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_raddr2(z80fi_mem_raddr2),
    .z80fi_mem_rdata(z80fi_mem_rdata)
  );

  // Memory responder: acks after `waits` idle cycles, never acks the stall address.
  always @(negedge clk) begin
    if (mem_rd && reset_n) begin
      if (stall_en && mem_addr == stall_addr) mem_ack = 1'b0;
      else if (wcnt >= waits) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        acc_log.push_back(mem_addr);
        wcnt     = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] pc);
    @(negedge clk);
    start = 1'b1;
    pc_in = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) of the terminating pulse, or -1.
  task automatic wait_end(input int n0, output int n);
    n = n0;
    #1;
    while (!(done || illegal || bus_err) && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(done || illegal || bus_err)) n = -1;
  endtask

  task automatic put4(input logic [15:0] a, input logic [7:0] b0, b1, b2, b3);
    mem[a] = b0; mem[a + 16'd1] = b1; mem[a + 16'd2] = b2; mem[a + 16'd3] = b3;
  endtask

  initial begin
    int n, cnt;
    logic [15:0] pc, nn;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put4(16'h0100, 8'hED, 8'h5B, 8'h34, 8'h12);
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    put4(16'h0300, 8'hED, 8'h7B, 8'hFF, 8'hFF);
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    mem[16'hFFFE] = 8'hED; mem[16'h0001] = 8'h40;   // opcode at FFFF set later
    mem[16'h4022] = 8'h5A; mem[16'h4023] = 8'hA5;
    put4(16'h0400, 8'hED, 8'h43, 8'h34, 8'h12);
    put4(16'h0600, 8'hED, 8'h4B, 8'h00, 8'h50);
    for (int i = 0; i < 4; i++) begin
      pc = 16'h0200 + 16'(i * 16);
      nn = 16'h3000 + 16'(i * 4);
      put4(pc, 8'hED, 8'h4B + 8'(i * 16), nn[7:0], nn[15:8]);
      mem[nn] = 8'h10 + 8'(i); mem[nn + 16'd1] = 8'hC0 + 8'(i);
    end

    reset_n = 1'b0; start = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_data = '0;
    waits = 0; wcnt = 0; stall_en = 1'b0; stall_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_mem_rd", mem_rd, 0);
    chk("rst_done", done, 0);       chk("rst_reg_wr", reg_wr, 0);
    chk("rst_illegal", illegal, 0); chk("rst_bus_err", bus_err, 0);
    chk("rst_wnum", reg_wnum, 0);   chk("rst_wdata", reg_wdata, 0);
    chk("rst_pcw", pc_wdata, 0);    chk("rst_insn", z80fi_insn, 0);
    chk("rst_len", z80fi_insn_len, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic zero-wait execution
    launch(16'h0100);
    wait_end(1, n);
    chk("A_latency", n, 7);         chk("A_done", done, 1);
    chk("A_reg_wr", reg_wr, 1);     chk("A_valid", z80fi_valid, 1);
    chk("A_busy", busy, 0);         chk("A_wnum", reg_wnum, 4'b1001);
    chk("A_wdata", reg_wdata, 16'hABCD);
    chk("A_pcw", pc_wdata, 16'h0104);
    chk("A_insn", z80fi_insn, 32'h12345BED);
    chk("A_len", z80fi_insn_len, 4);
    chk("A_raddr", z80fi_mem_raddr, 16'h1234);
    chk("A_raddr2", z80fi_mem_raddr2, 16'h1235);
    chk("A_rdata", z80fi_mem_rdata, 16'hABCD);
    step();
    chk("A_done_pulse", done, 0);
    chk("A_insn_hold", z80fi_insn, 32'h12345BED);

    // Every dd with 3 wait states per access
    waits = 3;
    for (int i = 0; i < 4; i++) begin
      launch(16'h0200 + 16'(i * 16));
      wait_end(1, n);
      chk("D_latency", n, 25);
      chk("D_done", done, 1);
      chk("D_wnum", reg_wnum, 4'h8 + 4'(i));
      chk("D_wdata", reg_wdata, {8'hC0 + 8'(i), 8'h10 + 8'(i)});
    end
    waits = 0;

    // nn = FFFF wraps the second data read to 0000
    launch(16'h0300);
    wait_end(1, n);
    chk("W_done", done, 1);
    chk("W_wdata", reg_wdata, 16'h2211);
    chk("W_raddr", z80fi_mem_raddr, 16'hFFFF);
    chk("W_raddr2", z80fi_mem_raddr2, 16'h0000);
    chk("W_wnum", reg_wnum, 4'hB);

    // PC = FFFE wraps the instruction fetch
    mem[16'hFFFF] = 8'h6B;
    acc_log.delete();
    launch(16'hFFFE);
    wait_end(1, n);
    chk("P_done", done, 1);
    chk("P_nacc", acc_log.size(), 6);
    if (acc_log.size() == 6) begin
      chk("P_a0", acc_log[0], 16'hFFFE); chk("P_a1", acc_log[1], 16'hFFFF);
      chk("P_a2", acc_log[2], 16'h0000); chk("P_a3", acc_log[3], 16'h0001);
      chk("P_a4", acc_log[4], 16'h4022);
    end
    chk("P_pcw", pc_wdata, 16'h0002);
    chk("P_wdata", reg_wdata, 16'hA55A);
    chk("P_wnum", reg_wnum, 4'hA);

    // Store opcode ED 43 is rejected after the opcode fetch
    launch(16'h0400);
    wait_end(1, n);
    chk("I43_cycle", n, 3);          chk("I43_illegal", illegal, 1);
    chk("I43_done", done, 0);        chk("I43_reg_wr", reg_wr, 0);
    chk("I43_busy", busy, 0);
    chk("I43_wdata_hold", reg_wdata, 16'hA55A);
    step();
    chk("I43_pulse", illegal, 0);

    // Non-ED first byte; start during the illegal pulse is ignored
    launch(16'h0500);
    wait_end(1, n);
    chk("I00_cycle", n, 2);          chk("I00_illegal", illegal, 1);
    start = 1'b1; pc_in = 16'h0100;
    step();
    start = 1'b0;
    chk("I00_start_ign_busy", busy, 0);
    chk("I00_start_ign_rd", mem_rd, 0);

    // Ack withheld in R_LO for MAX_WAIT cycles
    stall_en = 1'b1; stall_addr = 16'h5000;
    launch(16'h0600);
    wait_end(1, n);
    chk("B_cycle", n, 260);          chk("B_bus_err", bus_err, 1);
    chk("B_done", done, 0);          chk("B_busy", busy, 0);
    chk("B_illegal", illegal, 0);
    stall_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_err || reg_wr) cnt++;
    end
    chk("B_single_pulse", cnt, 0);
    launch(16'h0100);
    wait_end(1, n);
    chk("B_after_latency", n, 7);
    chk("B_after_wdata", reg_wdata, 16'hABCD);

    // Asynchronous reset during R_HI
    waits = 3;
    launch(16'h0100);
    n = 1;
    repeat (21) step();
    chk("R_in_rhi_addr", mem_addr, 16'h1235);
    reset_n = 1'b0;
    #1;
    chk("R_busy", busy, 0);          chk("R_mem_rd", mem_rd, 0);
    chk("R_addr", mem_addr, 0);      chk("R_wdata", reg_wdata, 0);
    chk("R_pcw", pc_wdata, 0);       chk("R_insn", z80fi_insn, 0);
    step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || reg_wr || illegal || bus_err) cnt++;
    end
    chk("R_no_pulses", cnt, 0);
    waits = 0;

    // start while busy is ignored
    launch(16'h0100);
    step(); step();
    start = 1'b1; pc_in = 16'h0700;
    step();
    start = 1'b0;
    wait_end(4, n);
    chk("S_latency", n, 7);
    chk("S_wdata", reg_wdata, 16'hABCD);
    chk("S_pcw", pc_wdata, 16'h0104);
    step();
    chk("S_idle_busy", busy, 0);
    step();
    chk("S_idle_rd", mem_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_ld_dd_extaddr_exec.md
Name: z80_ld_dd_extaddr_exec

Overview:
- Sequential executor for the 16-bit load LD dd, (nn), encoded ED 01dd1011 nnL nnH.
- Fetches the 4 instruction bytes from PC over a request/acknowledge memory bus, then reads memory at nn and nn+1, little-endian.
- Writes the result to register pair dd and reports the retired instruction on z80fi-style trace outputs, so the formal instruction spec can check it.
- Sits in the core's ED-prefix execution path; it is the memory-to-register counterpart of the LD (nn), dd store.

Parameters:
- MAX_WAIT, 255: maximum wait cycles per bus request before the executor aborts with bus_err.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to execute at pc_in; ignored while busy.
- pc_in  in  16  address of the ED byte.
- busy  out  1  high from the cycle after an accepted start until done, illegal or bus_err.
- mem_rd  out  1  bus read request; held until mem_ack.
- mem_addr  out  16  read address, valid while mem_rd is high.
- mem_ack  in  1  read completes this cycle.
- mem_data  in  8  read data, sampled when mem_ack is high.
- reg_wr  out  1  one-cycle register write strobe.
- reg_wnum  out  4  {2'b10, dd}.
- reg_wdata  out  16  {data at nn+1, data at nn}.
- pc_wdata  out  16  pc_in+4 mod 2^16.
- done  out  1  one-cycle pulse, coincident with reg_wr.
- illegal  out  1  one-cycle pulse on opcode mismatch.
- bus_err  out  1  one-cycle pulse on wait timeout.
- z80fi_valid  out  1  equals done.
- z80fi_insn  out  32  {nnH, nnL, opcode, ED}.
- z80fi_insn_len  out  4  4 on retire.
- z80fi_mem_raddr  out  16  nn.
- z80fi_mem_raddr2  out  16  nn+1 mod 2^16.
- z80fi_mem_rdata  out  16  {byte at nn+1, byte at nn}.

Behaviour:
- Reset (async, reset_n low): state IDLE; all strobes, mem_rd and busy low; every data and trace register 0. Takes effect mid-operation with no register write and no pulses; the outstanding request is dropped.
- States: IDLE → F_ED → F_OP → F_NL → F_NH → R_LO → R_HI → WB → IDLE.
- IDLE: on start, latch pc_in into pc_q and go to F_ED.
- F_ED, F_OP, F_NL, F_NH: mem_rd=1 with mem_addr = pc_q+0, +1, +2, +3 respectively, mod 2^16. On mem_ack, capture the byte and advance.
- F_ED: a byte other than 8'hED pulses illegal next cycle and returns to IDLE.
- F_OP: the byte must match pattern 01xx1011; otherwise pulse illegal and return to IDLE. dd = byte[5:4].
- R_LO: mem_addr = nn. R_HI: mem_addr = nn+1, wrapping 16'hFFFF to 16'h0000.
- WB: for exactly one cycle assert reg_wr, done and z80fi_valid, with reg_wdata, pc_wdata and trace outputs valid; then return to IDLE.
- The trace outputs hold their values until the next retire.
- mem_addr holds while mem_rd is high. mem_rd drops in the cycle after mem_ack, or moves directly to the next request.
- mem_ack is ignored when mem_rd is low.
- Wait counter: cleared at every request entry and incremented on each cycle without ack. If it reaches MAX_WAIT with no ack, pulse bus_err, return to IDLE, no register write.
- Latency with zero wait states (ack in the same cycle as request): start at cycle 0, F_ED at 1, done at cycle 7.
- The illegal, bus_err and done pulses are mutually exclusive.
- busy drops in the same cycle the terminating pulse is asserted. start in that cycle is ignored; start is accepted in the following cycle.

Decomposition:
- Shared package z80_exec_pkg holds:
  - state enum for the executor;
  - ED_PREFIX = 8'hED;
  - the LD_DD_NN opcode mask/match (8'hCF / 8'h4B);
  - REGPAIR_BASE = 2'b10.
- One natural sub-module, z80_bus_req_timer: holds the request and wait counter and produces timeout. It is reused by other multi-byte executors.

Test Plan:
- PC=16'h0100, memory ED 5B 34 12, [1234]=CD, [1235]=AB, zero waits → done at cycle 7, reg_wnum=4'b1001, reg_wdata=16'hABCD, pc_wdata=16'h0104, z80fi_insn=32'h12345BED.
- Each dd, opcodes 4B/5B/6B/7B → reg_wnum 8/9/A/B; 3 wait cycles per access → done at cycle 25.
- nn=16'hFFFF, [FFFF]=11, [0000]=22; PC=16'hFFFE → fetch addresses FFFE, FFFF, 0000, 0001; reg_wdata=16'h2211; z80fi_mem_raddr2=16'h0000; pc_wdata=16'h0002.
- Bytes ED 43 (LD (nn),dd encoding) → illegal pulse after the F_OP ack; no reg_wr; busy low next cycle. First byte 8'h00 → illegal after F_ED.
- mem_ack held low for MAX_WAIT cycles in R_LO → single bus_err pulse, no reg_wr, return to IDLE; a subsequent start executes normally.
- reset_n asserted low during R_HI → outputs 0 immediately, no done. start during busy → ignored, and the result matches a single execution.
